// File: rtl/inst_fetch_if.sv
// Instruction-SRAM-like bus: one request/address handshake, one data return.
interface inst_fetch_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch responder: issues one bus fetch per PC, buffers the word
// until IF/ID accepts it, and drops in-flight data after a flush.
module inst_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic        if_req_en,
  input  logic        id_stall,
  input  logic        flush,
  output logic        stallreq,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid,
  output logic        adel_o,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic        cancel, cancel_n;
  logic        req_q, req_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] pc_n, inst_n;
  logic        valid_n, adel_n;
  logic        take;

  assign bus.inst_sram_req  = req_q;
  assign bus.inst_sram_addr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      inst_o     <= '0;
      inst_pc_o  <= '0;
      inst_valid <= 1'b0;
      adel_o     <= 1'b0;
    end else begin
      state      <= state_n;
      cancel     <= cancel_n;
      req_q      <= req_n;
      addr_q     <= addr_n;
      inst_o     <= inst_n;
      inst_pc_o  <= pc_n;
      inst_valid <= valid_n;
      adel_o     <= adel_n;
    end
  end

  always_comb begin
    state_n  = state;
    cancel_n = cancel;
    addr_n   = addr_q;
    pc_n     = inst_pc_o;
    inst_n   = inst_o;
    valid_n  = inst_valid;
    adel_n   = adel_o;
    stallreq = 1'b0;
    take     = 1'b0;
    case (state)
      IDLE: if (if_req_en && !flush) begin
        take     = 1'b1;
        stallreq = 1'b1;
      end
      // req/addr stay put through a flush; only the returned data is dropped
      REQ: begin
        stallreq = !cancel;
        if (flush) cancel_n = 1'b1;
        if (bus.inst_sram_addr_ok) state_n = WAIT;
      end
      WAIT: begin
        stallreq = !cancel;
        if (flush) cancel_n = 1'b1;
        if (bus.inst_sram_data_ok) begin
          if (cancel || flush) begin
            cancel_n = 1'b0;
            state_n  = IDLE;
          end else begin
            inst_n  = bus.inst_sram_rdata;
            adel_n  = 1'b0;
            valid_n = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (flush) begin
          state_n = IDLE;
          valid_n = 1'b0;
          adel_n  = 1'b0;
        end else if (!id_stall) begin
          if (if_req_en) begin
            take     = 1'b1;
            stallreq = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            adel_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Misaligned PCs never reach the bus; they complete at once with adel_o.
    if (take) begin
      pc_n = if_pc;
      if (if_pc[1:0] == 2'b00) begin
        addr_n  = if_pc;
        valid_n = 1'b0;
        adel_n  = 1'b0;
        state_n = REQ;
      end else begin
        inst_n  = '0;
        valid_n = 1'b1;
        adel_n  = 1'b1;
        state_n = DONE;
      end
    end
  end

  assign req_n = (state_n == REQ);
endmodule
